adder_64_arb: RTL and testbench
===============================

Name: adder_64_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational 64-bit adder (adder_64) between NUM_REQ requesters.
- Accepts operand requests over valid/ready, drives the adder from registered operands, captures sum/cout, and returns the result tagged with the requester ID over a valid/ready response port.
- Sits between client blocks and the single adder_64 instance in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 64, operand width; must match the adder instance.
- ID_W, 2, requester ID width; must satisfy ID_W >= clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_in1  in  NUM_REQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_in2  in  NUM_REQ*WIDTH  packed operand B, same packing.
- req_cin  in  NUM_REQ  per-requester carry-in.
- add_in1  out  WIDTH  to adder in1.
- add_in2  out  WIDTH  to adder in2.
- add_cin  out  1  to adder cin.
- add_sum  in  WIDTH  from adder sum.
- add_cout  in  1  from adder cout.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  WIDTH  registered sum.
- rsp_cout  out  1  registered carry-out.
- rsp_id  out  ID_W  index of the requester that owns the result.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - All outputs are 0: req_ready, add_in1, add_in2, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id.
  - Reset mid-operation abandons the in-flight operation. No response is produced for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is driven combinationally. It is one-hot on the winner when any req_valid is high, else 0.
  - Winner is the first asserted req_valid searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - On an edge with a winner: latch winner operands into add_in1/add_in2/add_cin; latch rsp_id=winner; set rr_ptr=winner; go to EXEC.
  - Handshake completes on the same cycle req_valid[i] & req_ready[i] is high.
- EXEC (one cycle): add_* are held stable. At the edge, capture add_sum into rsp_sum and add_cout into rsp_cout, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid=1. rsp_sum, rsp_cout and rsp_id are held stable until rsp_valid & rsp_ready.
  - On acceptance: rsp_valid=0, go to IDLE.
  - req_ready=0 throughout EXEC and RESP.
- Latency and throughput:
  - Request accept to rsp_valid = 2 cycles.
  - Best-case throughput is one operation per 3 cycles (IDLE, EXEC, RESP with rsp_ready=1).
- Arithmetic: {rsp_cout, rsp_sum} = in1 + in2 + cin, modulo 2^(WIDTH+1). The wrap case is all-ones + 1 → sum=0, cout=1.
- Fairness and request rules:
  - A requester granted once is not granted again while any other requester is valid.
  - A requester deasserting req_valid before grant is simply not considered.
  - Simultaneous requests resolve per rr_ptr only.
- rsp_ready arriving before rsp_valid has no effect.
- add_* hold their last value in IDLE. They are not cleared except by reset.

Optional Feature:
- Macro ADDER_ARB_SUB_EN.
- With the macro defined:
  - Adds input port req_sub (NUM_REQ bits).
  - A granted request with req_sub[i]=1 latches add_in2=~in2 and add_cin=1, ignoring req_cin, so the result is in1-in2. rsp_cout=1 means no borrow.
- Without the macro: port absent; all requests are additions.

Test Plan:
- Single request: req0 in1=64'h1, in2=64'h2, cin=1, rsp_ready=1.
  - req_ready[0] high in the accept cycle.
  - rsp_valid 2 cycles later with sum=64'h4, cout=0, id=0.
- Wrap: in1=64'hFFFF_FFFF_FFFF_FFFF, in2=0, cin=1 → sum=0, cout=1.
  - Also in1=in2=64'h8000_0000_0000_0000, cin=0 → sum=0, cout=1.
- Round-robin: all 4 req_valid held high for 8 operations, rsp_ready=1 → grant order 0,1,2,3,0,1,2,3.
  - Each result carries the matching id and sum.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_sum/rsp_id stay stable and req_ready stays 0.
  - Raise rsp_ready → one-cycle accept, then the next grant.
- Reset mid-op: assert rst while in EXEC.
  - Next cycle all outputs are 0 and no rsp_valid appears.
  - A subsequent request from req3 and req0 grants req0 first.
- ADDER_ARB_SUB_EN: req_sub=1, in1=64'd10, in2=64'd3 → sum=64'd7, cout=1.
  - in1=3, in2=10 → sum=64'hFFFF_FFFF_FFFF_FFF9, cout=0.

Source files
------------

// File: rtl/adder_64_arb.sv
// adder_64_arb: round-robin arbiter that shares one combinational adder_64
// between NUM_REQ requesters. Operands are registered toward the adder, the
// result is captured one cycle later and returned with the owner's ID.
// Optional feature macro: ADDER_ARB_SUB_EN adds a per-requester req_sub port
// that turns a granted request into in1 - in2.
module adder_64_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in2,
  input  logic [NUM_REQ-1:0]         req_cin,
`ifdef ADDER_ARB_SUB_EN
  input  logic [NUM_REQ-1:0]         req_sub,
`endif
  output logic [WIDTH-1:0]           add_in1,
  output logic [WIDTH-1:0]           add_in2,
  output logic                       add_cin,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_cout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic [ID_W-1:0]            rsp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic [WIDTH-1:0]  sel_in1;
  logic [WIDTH-1:0]  sel_in2;
  logic              sel_cin;

  // Search for the first valid requester after the last winner, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pick the winner's operands; subtraction inverts in2 and forces carry-in.
  always_comb begin
    sel_in1 = req_in1[int'(grant_idx)*WIDTH +: WIDTH];
    sel_in2 = req_in2[int'(grant_idx)*WIDTH +: WIDTH];
    sel_cin = req_cin[grant_idx];
`ifdef ADDER_ARB_SUB_EN
    if (req_sub[grant_idx]) begin
      sel_in2 = ~req_in2[int'(grant_idx)*WIDTH +: WIDTH];
      sel_cin = 1'b1;
    end
`endif
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the combinational grant, which only exists in IDLE.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch on grant, result capture after the adder cycle, response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      add_in1   <= '0;
      add_in2   <= '0;
      add_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            add_in1 <= sel_in1;
            add_in2 <= sel_in2;
            add_cin <= sel_cin;
            rsp_id  <= grant_idx;
            rr_ptr  <= grant_idx;
          end
        end
        EXEC: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_64_arb.sv
// Testbench for adder_64_arb: models the external adder_64, drives directed
// requests, and scores responses through an expectation queue.
module tb_adder_64_arb;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 64;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_in1;
  logic [NUM_REQ*WIDTH-1:0] req_in2;
  logic [NUM_REQ-1:0]       req_cin;
`ifdef ADDER_ARB_SUB_EN
  logic [NUM_REQ-1:0]       req_sub;
`endif
  logic [WIDTH-1:0]         add_in1;
  logic [WIDTH-1:0]         add_in2;
  logic                     add_cin;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_cout;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic [ID_W-1:0]          rsp_id;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  int   checks = 0;
  int   passes = 0;

  logic [WIDTH-1:0] rr_sum  [NUM_REQ];
  logic             rr_cout [NUM_REQ];

  adder_64_arb #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH),
    .ID_W   (ID_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_in1  (req_in1),
    .req_in2  (req_in2),
    .req_cin  (req_cin),
`ifdef ADDER_ARB_SUB_EN
    .req_sub  (req_sub),
`endif
    .add_in1  (add_in1),
    .add_in2  (add_in2),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_cout (rsp_cout),
    .rsp_id   (rsp_id)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared adder_64 instance.
  assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + {{WIDTH{1'b0}}, add_cin};

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Score every accepted response against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL rsp_unexpected: got id %0d sum %h, expected no response", rsp_id, rsp_sum);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("rsp_id", WIDTH'(rsp_id), WIDTH'(mon_exp.id));
        checkOutput("rsp_sum", rsp_sum, mon_exp.sum);
        checkOutput("rsp_cout", WIDTH'(rsp_cout), WIDTH'(mon_exp.cout));
      end
    end
  end

  task automatic checkReset(input string name);
    checkOutput({name, "_req_ready"}, WIDTH'(req_ready), '0);
    checkOutput({name, "_add_in1"}, add_in1, '0);
    checkOutput({name, "_add_in2"}, add_in2, '0);
    checkOutput({name, "_add_cin"}, WIDTH'(add_cin), '0);
    checkOutput({name, "_rsp_valid"}, WIDTH'(rsp_valid), '0);
    checkOutput({name, "_rsp_sum"}, rsp_sum, '0);
    checkOutput({name, "_rsp_cout"}, WIDTH'(rsp_cout), '0);
    checkOutput({name, "_rsp_id"}, WIDTH'(rsp_id), '0);
  endtask

  task automatic set_req(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic s);
    req_in1[idx*WIDTH +: WIDTH] = a;
    req_in2[idx*WIDTH +: WIDTH] = b;
    req_cin[idx] = c;
`ifdef ADDER_ARB_SUB_EN
    req_sub[idx] = s;
`else
    if (s) $display("[TB] note: subtract request issued without subtract support");
`endif
    req_valid[idx] = 1'b1;
  endtask

  task automatic push_exp(input int idx, input logic [WIDTH-1:0] sum, input logic cout);
    exp_t e;
    e.id   = ID_W'(idx);
    e.cout = cout;
    e.sum  = sum;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string name, input int idx);
    int n;
    logic [NUM_REQ-1:0] oh;
    n = 0;
    oh = '0;
    oh[idx] = 1'b1;
    @(negedge clk);
    while (!req_ready[idx] && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_grant"}, WIDTH'(req_ready), WIDTH'(oh));
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input int idx, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic c, input logic s,
                               input logic [WIDTH-1:0] esum, input logic ecout);
    set_req(idx, a, b, c, s);
    push_exp(idx, esum, ecout);
    wait_grant(name, idx);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput({name, "_drain"}, WIDTH'(sb.size()), '0);
  endtask

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int grants;
    int cyc;
    logic seen;
    logic [NUM_REQ-1:0] oh;

    rst       = 1'b1;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    req_cin   = '0;
`ifdef ADDER_ARB_SUB_EN
    req_sub   = '0;
`endif
    rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request with latency checks.
    rsp_ready = 1'b1;
    set_req(0, 64'h1, 64'h2, 1'b1, 1'b0);
    push_exp(0, 64'h4, 1'b0);
    @(negedge clk);
    checkOutput("single_ready", WIDTH'(req_ready), WIDTH'(4'b0001));
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("single_exec_valid", WIDTH'(rsp_valid), '0);
    checkOutput("single_add_in1", add_in1, 64'h1);
    @(negedge clk);
    checkOutput("single_latency", WIDTH'(rsp_valid), WIDTH'(1));
    @(posedge clk);
    #1;
    checkOutput("single_drain", WIDTH'(sb.size()), '0);

    // Wrap cases.
    applyStimulus("wrap1", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
    drain("wrap1");
    applyStimulus("wrap2", 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                  64'h0, 1'b1);
    drain("wrap2");
    checkOutput("idle_hold_in1", add_in1, 64'h8000_0000_0000_0000);

    // Round-robin with all requesters held valid, starting from a fresh reset.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(0, 64'h10, 64'h01, 1'b0, 1'b0);
    set_req(1, 64'h20, 64'h02, 1'b1, 1'b0);
    set_req(2, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
    set_req(3, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    rr_sum[0] = 64'h11;                  rr_cout[0] = 1'b0;
    rr_sum[1] = 64'h23;                  rr_cout[1] = 1'b0;
    rr_sum[2] = 64'h0;                   rr_cout[2] = 1'b1;
    rr_sum[3] = 64'h2345_6789_ABCD_F001; rr_cout[3] = 1'b0;
    for (int i = 0; i < 8; i++) push_exp(i % NUM_REQ, rr_sum[i % NUM_REQ], rr_cout[i % NUM_REQ]);
    grants = 0;
    cyc = 0;
    while (grants < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        oh = '0;
        oh[grants % NUM_REQ] = 1'b1;
        checkOutput("rr_order", WIDTH'(req_ready), WIDTH'(oh));
        grants++;
        if (grants == 8) begin
          @(posedge clk);
          #1 req_valid = '0;
        end
      end
    end
    req_valid = '0;
    checkOutput("rr_grants", WIDTH'(grants), WIDTH'(8));
    drain("rr");

    // Backpressure: hold the response for several cycles with another requester waiting.
    rsp_ready = 1'b0;
    applyStimulus("bp2", 2, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_CAFE_F00D, 1'b0, 1'b0,
                  64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    set_req(1, 64'h5, 64'h7, 1'b0, 1'b0);
    push_exp(1, 64'hC, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_valid", WIDTH'(rsp_valid), WIDTH'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", WIDTH'(rsp_valid), WIDTH'(1));
      checkOutput("bp_hold_sum", rsp_sum, 64'hDEAD_BEEF_CAFE_F00D);
      checkOutput("bp_hold_id", WIDTH'(rsp_id), WIDTH'(2));
      checkOutput("bp_hold_ready", WIDTH'(req_ready), '0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_next_grant", WIDTH'(req_ready), WIDTH'(4'b0010));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    drain("bp");

    // Reset while the adder cycle is in flight.
    set_req(1, 64'h1, 64'h1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrst_grant", WIDTH'(req_ready), WIDTH'(4'b0010));
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    checkReset("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    checkOutput("midrst_no_rsp", WIDTH'(seen), '0);
    @(posedge clk);
    #1;
    set_req(3, 64'h0F, 64'hF0, 1'b0, 1'b0);
    set_req(0, 64'h7, 64'h8, 1'b1, 1'b0);
    push_exp(0, 64'h10, 1'b0);
    push_exp(3, 64'hFF, 1'b0);
    wait_grant("pair0", 0);
    wait_grant("pair3", 3);
    drain("pair");

`ifdef ADDER_ARB_SUB_EN
    // Subtraction: carry-in is forced, so req_cin is ignored.
    applyStimulus("sub1", 0, 64'd10, 64'd3, 1'b0, 1'b1, 64'd7, 1'b1);
    drain("sub1");
    applyStimulus("sub2", 0, 64'd3, 64'd10, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    drain("sub2");
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
